// File: rtl/sr_cmd_encoder.sv
// rtl/sr_cmd_encoder.sv - debounced level-to-SR-latch command encoder
// Converts a noisy level into fixed-width set/reset pulses and tracks the latch level.
module sr_cmd_encoder #(
  parameter int DB_CYCLES    = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic s,
  output logic r,
  output logic q_est,
  output logic busy
);

  typedef enum logic [2:0] {
    INIT,
    IDLE_LOW,
    CONFIRM_HIGH,
    SET_PULSE,
    IDLE_HIGH,
    CONFIRM_LOW,
    RST_PULSE
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             sync1_q, sync2_q;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             q_est_q, q_est_d;
  logic             busy_q, busy_d;
  logic             din_s;

  assign din_s   = sync2_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    r_d     = r_q;
    q_est_d = q_est_q;
    case (state_q)
      INIT: begin
        // r_q low here means this is the first edge after reset release
        if (!r_q) begin
          r_d   = 1'b1;
          cnt_d = CNT_ONE;
        end else if (cnt_q >= PULSE_LAST) begin
          r_d     = 1'b0;
          cnt_d   = '0;
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE_LOW: begin
        if (en && din_s) begin
          if (DB_CYCLES <= 1) begin
            state_d = SET_PULSE;
            s_d     = 1'b1;
            q_est_d = 1'b1;
          end else begin
            state_d = CONFIRM_HIGH;
          end
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CONFIRM_HIGH: begin
        if (en && din_s) begin
          if (cnt_q >= DB_LAST) begin
            state_d = SET_PULSE;
            s_d     = 1'b1;
            q_est_d = 1'b1;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end
      end
      SET_PULSE: begin
        if (cnt_q >= PULSE_LAST) begin
          s_d     = 1'b0;
          cnt_d   = '0;
          state_d = IDLE_HIGH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE_HIGH: begin
        if (en && !din_s) begin
          if (DB_CYCLES <= 1) begin
            state_d = RST_PULSE;
            r_d     = 1'b1;
            q_est_d = 1'b0;
          end else begin
            state_d = CONFIRM_LOW;
          end
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CONFIRM_LOW: begin
        if (en && !din_s) begin
          if (cnt_q >= DB_LAST) begin
            state_d = RST_PULSE;
            r_d     = 1'b1;
            q_est_d = 1'b0;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end
      end
      RST_PULSE: begin
        if (cnt_q >= PULSE_LAST) begin
          r_d     = 1'b0;
          cnt_d   = '0;
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
        s_d     = 1'b0;
        r_d     = 1'b0;
        q_est_d = 1'b0;
      end
    endcase
    busy_d = (state_d == INIT) || (state_d == CONFIRM_HIGH) || (state_d == SET_PULSE) ||
             (state_d == CONFIRM_LOW) || (state_d == RST_PULSE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      q_est_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= din;
      sync2_q <= sync1_q;
      s_q     <= s_d;
      r_q     <= r_d;
      q_est_q <= q_est_d;
      busy_q  <= busy_d;
    end
  end

  assign s     = s_q;
  assign r     = r_q;
  assign q_est = q_est_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sr_cmd_encoder.sv
// tb/tb_sr_cmd_encoder.sv - scoreboard bench for sr_cmd_encoder
// Two instances (default timing and the DB=1/PULSE=1 corner) share one stimulus stream.
module tb_sr_cmd_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, din, en;
  logic s0, r0, q0, b0;
  logic s1, r1, q1, b1;

  sr_cmd_encoder #(.DB_CYCLES(4), .PULSE_CYCLES(2), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .din(din), .en(en),
    .s(s0), .r(r0), .q_est(q0), .busy(b0)
  );

  sr_cmd_encoder #(.DB_CYCLES(1), .PULSE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .din(din), .en(en),
    .s(s1), .r(r1), .q_est(q1), .busy(b1)
  );

  int checks   = 0;
  int failures = 0;
  int cycle_n  = 0;
  logic [7:0] exp_q[$];

  // Abstract model: a pending-pulse length, a run of enabled samples that
  // disagree with the believed level, and the raw din history seen through
  // two sample delays.
  int db_c[2] = '{4, 1};
  int pw_c[2] = '{2, 1};
  bit pre[2];
  int pulse_left[2];
  bit kind[2];
  bit lvl[2];
  int run[2];
  bit hist[2][2];

  task automatic model_step(input int i, input bit rv, input bit dv, input bit ev,
                            output logic [3:0] e);
    bit ds;
    if (!rv) begin
      pre[i] = 1'b1; pulse_left[i] = 0; run[i] = 0; lvl[i] = 1'b0; kind[i] = 1'b0;
      hist[i][0] = 1'b0; hist[i][1] = 1'b0;
    end else begin
      ds = hist[i][0];
      hist[i][0] = hist[i][1];
      hist[i][1] = dv;
      if (pre[i]) begin
        pre[i] = 1'b0; pulse_left[i] = pw_c[i]; kind[i] = 1'b0;
      end else if (pulse_left[i] > 0) begin
        pulse_left[i]--;
      end else if (ev && ds != lvl[i]) begin
        run[i]++;
        if (run[i] == db_c[i]) begin
          pulse_left[i] = pw_c[i]; kind[i] = ds; lvl[i] = ds; run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    e[3] = (pulse_left[i] > 0) && kind[i];
    e[2] = (pulse_left[i] > 0) && !kind[i];
    e[1] = lvl[i];
    e[0] = (pulse_left[i] > 0) || (run[i] > 0);
  endtask

  task automatic drive(input bit rv, input bit dv, input bit ev);
    logic [3:0] e0, e1;
    @(negedge clk);
    rst = rv; din = dv; en = ev;
    @(posedge clk);
    cycle_n++;
    model_step(0, rv, dv, ev, e0);
    model_step(1, rv, dv, ev, e1);
    exp_q.push_back({e0, e1});
  endtask

  task automatic hold(input bit rv, input bit dv, input bit ev, input int n);
    for (int k = 0; k < n; k++) drive(rv, dv, ev);
  endtask

  initial begin
    logic [7:0] e;
    logic [3:0] a0, a1;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        a0 = {s0, r0, q0, b0};
        a1 = {s1, r1, q1, b1};
        checks++;
        if (a0 !== e[7:4]) begin
          failures++;
          $display("FAIL enc_db4 cycle %0d: {s,r,q_est,busy} actual=%b required=%b",
                   cycle_n, a0, e[7:4]);
        end
        checks++;
        if (a1 !== e[3:0]) begin
          failures++;
          $display("FAIL enc_db1 cycle %0d: {s,r,q_est,busy} actual=%b required=%b",
                   cycle_n, a1, e[3:0]);
        end
      end
    end
  end

  initial begin
    bit dv, ev;
    int len;
    rst = 1'b0; din = 1'b0; en = 1'b1;
    hold(0, 0, 1, 3);
    hold(1, 0, 1, 10);
    hold(1, 1, 1, 12);
    hold(1, 0, 1, 12);
    hold(1, 1, 1, 3);
    hold(1, 0, 1, 10);
    hold(1, 1, 1, 6);
    hold(1, 0, 1, 15);
    hold(1, 1, 0, 10);
    hold(1, 1, 1, 12);
    hold(1, 0, 1, 12);
    hold(1, 1, 1, 6);
    hold(0, 1, 1, 1);
    hold(1, 1, 1, 15);
    hold(1, 0, 1, 12);
    for (int seg = 0; seg < 600; seg++) begin
      dv  = 1'($urandom_range(0, 1));
      ev  = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 10);
      if ($urandom_range(0, 60) == 0) hold(0, dv, ev, $urandom_range(1, 2));
      hold(1, dv, ev, len);
    end
    hold(1, 0, 1, 4);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending expectations actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_cmd_encoder.md
Name: sr_cmd_encoder

Overview:
- Drives the set/reset inputs of a downstream SR latch from a single, possibly noisy, level input.
- Functions:
  - synchronises and debounces the input level;
  - on each confirmed edge, emits a fixed-width set pulse (rising) or reset pulse (falling);
  - issues one reset pulse after reset release, so the latch starts from a known state.
- Sits between a raw status/switch input and the latch; tracks the level it believes the latch holds.

Parameters:
- DB_CYCLES, 4: consecutive synchronised samples needed to confirm a level change (>=1).
- PULSE_CYCLES, 2: width in clocks of every s or r pulse (>=1).
- CNT_W, 8: width of the internal debounce/pulse counter; must hold max(DB_CYCLES, PULSE_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset; sampled on clk rising edge, 0 = reset.
- din  input  1  asynchronous level to be tracked.
- en  input  1  detection enable. 0 = no new edge accepted; a pulse in progress still completes.
- s  output  1  set command to latch, registered.
- r  output  1  reset command to latch, registered.
- q_est  output  1  level the latch is expected to hold, registered.
- busy  output  1  1 while in INIT, CONFIRM_* or *_PULSE states.

Behaviour:
- Reset (rst=0 at an edge):
  - s=0, r=0, q_est=0, busy=0.
  - Both synchroniser flops cleared to 0, counter=0, state=INIT.
  - Applies mid-pulse or mid-confirm too: everything is abandoned, with no partial pulse continuation.
- Synchroniser: two flops; din_s is din delayed two edges. The FSM sees only din_s.
- States: INIT, IDLE_LOW, CONFIRM_HIGH, SET_PULSE, IDLE_HIGH, CONFIRM_LOW, RST_PULSE.
- INIT:
  - Entered from reset.
  - First edge with rst=1: r=1, busy=1, cnt=1.
  - r is held for PULSE_CYCLES clocks, then r=0 and go to IDLE_LOW.
  - q_est stays 0.
- IDLE_LOW, en=1, din_s=1: counts as sample 1.
  - If DB_CYCLES=1, go directly to SET_PULSE.
  - Otherwise go to CONFIRM_HIGH with cnt=1.
- IDLE_LOW, otherwise: hold, cnt=0.
- CONFIRM_HIGH:
  - din_s=1: cnt++. The edge at which cnt would reach DB_CYCLES instead enters SET_PULSE.
  - din_s=0 or en=0: glitch rejected, return to IDLE_LOW, cnt=0, no output change.
- SET_PULSE:
  - On entry edge: s=1, q_est=1, cnt=1.
  - s is held for exactly PULSE_CYCLES clocks, then s=0 and go to IDLE_HIGH.
  - din_s and en are ignored while in this state.
- IDLE_HIGH / CONFIRM_LOW / RST_PULSE: mirror image, with din_s=0 as the trigger; r pulses and q_est becomes 0.
- Latency:
  - din first sampled high at edge k gives s=1 after edge k+1+DB_CYCLES.
  - s returns to 0 after edge k+1+DB_CYCLES+PULSE_CYCLES.
- Input changing during a pulse:
  - Not lost if still present: the opposite edge is evaluated from the IDLE state after the pulse.
  - The minimum gap between s and r pulses is therefore DB_CYCLES clocks.
- Invariants:
  - s and r are never 1 in the same cycle.
  - s is never asserted while q_est=1 before the pulse; r is never asserted while q_est=0 (except INIT).
- Counter saturates and never wraps; the CNT_W sizing check is done by the integrator.

Test Plan:
- Reset release, din=0, defaults (DB=4, PULSE=2): r=1 for exactly 2 cycles after the first rst=1 edge, then idle. s=0 throughout, q_est=0, busy low after the pulse.
- din 0->1, held: s=1 for 2 cycles starting after edge k+5 (k = first sampling edge), q_est=1 from the same edge. Then din 1->0: r=1 for 2 cycles, q_est=0.
- din glitch high for 3 cycles (< DB_CYCLES): no s pulse, q_est stays 0, state back to IDLE_LOW.
- din falls one cycle into the s pulse: s still lasts 2 cycles. Then r pulse after 4 confirm cycles. Never s and r both 1.
- en=0 while din toggles 0->1 and holds: no pulse. Raise en: s pulse follows after DB_CYCLES samples.
- Assert rst=0 during SET_PULSE: next edge s=0, q_est=0, sync cleared. On release: INIT r pulse of 2 cycles repeats.
